// File: rtl/ifcfg_tx.sv
// ifcfg_tx: host-loaded layer-config table streamed to the CCU over
// IFCFG_val/CFGIF_rdy. Optional macro IFCFG_LOOP_EN: wrap forever.
//
// Ports:
//   clk, rst (async, active-high)
//   host_wr_en/addr/data : table write port (dropped while busy)
//   host_num_layer       : layers per run, 1..DEPTH, sampled on start
//   host_start           : run request pulse
//   host_busy/host_done  : run status
//   CFGIF_rdy            : CCU ready
//   IFCFG_val/IFCFG_data : offered config word (registered)
//   cur_layer            : index offered or next to be offered
module ifcfg_tx #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_wr_en,
  input  logic [AW-1:0]         host_wr_addr,
  input  logic [DATA_WIDTH-1:0] host_wr_data,
  input  logic [AW:0]           host_num_layer,
  input  logic                  host_start,
  output logic                  host_busy,
  output logic                  host_done,
  input  logic                  CFGIF_rdy,
  output logic                  IFCFG_val,
  output logic [DATA_WIDTH-1:0] IFCFG_data,
  output logic [AW-1:0]         cur_layer
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [1:0]            state_q, state_d;
  logic [AW:0]           cnt_q, cnt_d;
  logic [AW-1:0]         cur_q, cur_d;
  logic                  val_q, val_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic xfer;
  logic last;
  logic start_ok;

  assign xfer     = (state_q == S_SEND) && val_q && CFGIF_rdy;
  assign last     = ({1'b0, cur_q} == (cnt_q - 1'b1));
  assign start_ok = host_start && (host_num_layer != '0) &&
                    (host_num_layer <= DEPTH_W);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    val_d   = val_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          cnt_d   = host_num_layer;
          cur_d   = '0;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // Table read lands directly in the output register.
        data_d  = mem_q[cur_q];
        val_d   = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (xfer) begin
          val_d = 1'b0;
          if (last) begin
            done_d = 1'b1;
`ifdef IFCFG_LOOP_EN
            cur_d   = '0;
            state_d = S_FETCH;
`else
            state_d = S_DONE;
`endif
          end else begin
            cur_d   = cur_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      val_q   <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      val_q   <= val_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Table survives reset; only idle-time writes are honoured.
  always_ff @(posedge clk) begin
    if (host_wr_en && !busy_q)
      mem_q[host_wr_addr] <= host_wr_data;
  end

  assign host_busy  = busy_q;
  assign host_done  = done_q;
  assign IFCFG_val  = val_q;
  assign IFCFG_data = data_q;
  assign cur_layer  = cur_q;

endmodule

// File: tb/tb_ifcfg_tx.sv
// tb_ifcfg_tx: vector-table bench for ifcfg_tx (default build).
// Rows give per-cycle inputs and the outputs expected in that cycle.
module tb_ifcfg_tx;

  logic         clk = 1'b0;
  logic         rst;
  logic         host_wr_en;
  logic [3:0]   host_wr_addr;
  logic [127:0] host_wr_data;
  logic [4:0]   host_num_layer;
  logic         host_start;
  logic         host_busy;
  logic         host_done;
  logic         CFGIF_rdy;
  logic         IFCFG_val;
  logic [127:0] IFCFG_data;
  logic [3:0]   cur_layer;

  always #5 clk = ~clk;

  ifcfg_tx dut (
    .clk           (clk),
    .rst           (rst),
    .host_wr_en    (host_wr_en),
    .host_wr_addr  (host_wr_addr),
    .host_wr_data  (host_wr_data),
    .host_num_layer(host_num_layer),
    .host_start    (host_start),
    .host_busy     (host_busy),
    .host_done     (host_done),
    .CFGIF_rdy     (CFGIF_rdy),
    .IFCFG_val     (IFCFG_val),
    .IFCFG_data    (IFCFG_data),
    .cur_layer     (cur_layer)
  );

  typedef struct {
    logic         wr;
    logic [3:0]   addr;
    logic [127:0] wd;
    logic [4:0]   num;
    logic         st;
    logic         rdy;
    logic         ev;
    logic [127:0] ed;
    logic         eb;
    logic         edn;
    logic [3:0]   ec;
  } vec_t;

  vec_t vq[$];
  logic [127:0] tab [16];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic void add(
    input logic wr, input logic [3:0] addr, input logic [127:0] wd,
    input logic [4:0] num, input logic st, input logic rdy,
    input logic ev, input logic [127:0] ed, input logic eb,
    input logic edn, input logic [3:0] ec);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wd = wd; v.num = num; v.st = st;
    v.rdy = rdy; v.ev = ev; v.ed = ed; v.eb = eb; v.edn = edn;
    v.ec = ec;
    vq.push_back(v);
  endfunction

  function automatic void idle(input logic [127:0] d,
                               input logic [3:0] c, input logic [4:0] n,
                               input logic st);
    add(0, 0, 0, n, st, 1, 0, d, 0, 0, c);
  endfunction

  // Full-speed run; inj drives a busy-time write to entry 2 plus a
  // second start during the first FETCH cycle.
  function automatic void run(input int n, input logic [127:0] pd,
                              input logic [3:0] pc, input bit inj);
    idle(pd, pc, 5'(n), 1);
    for (int k = 0; k < n; k++) begin
      if (inj && k == 0)
        add(1, 2, 128'hFF, 5'(n), 1, 1, 0, pd, 1, 0, 0);
      else
        add(0, 0, 0, 0, 0, 1, 0, (k == 0) ? pd : tab[k-1], 1, 0, 4'(k));
      add(0, 0, 0, 0, 0, 1, 1, tab[k], 1, 0, 4'(k));
    end
    add(0, 0, 0, 0, 0, 1, 0, tab[n-1], 1, 1, 4'(n-1));
    idle(tab[n-1], 4'(n-1), 0, 0);
  endfunction

  task automatic drive(input vec_t v);
    host_wr_en     = v.wr;
    host_wr_addr   = v.addr;
    host_wr_data   = v.wd;
    host_num_layer = v.num;
    host_start     = v.st;
    CFGIF_rdy      = v.rdy;
  endtask

  task automatic outs(input string nm, input logic ev,
                      input logic [127:0] ed, input logic eb,
                      input logic edn, input logic [3:0] ec);
    chk({nm, " val"},  128'(IFCFG_val),  128'(ev));
    chk({nm, " data"}, IFCFG_data,       ed);
    chk({nm, " busy"}, 128'(host_busy),  128'(eb));
    chk({nm, " done"}, 128'(host_done),  128'(edn));
    chk({nm, " cur"},  128'(cur_layer),  128'(ec));
  endtask

  initial begin
    vec_t z;
    for (int i = 0; i < 16; i++) tab[i] = 128'hA0 + 128'(i);

    for (int i = 0; i < 16; i++)
      add(1, 4'(i), tab[i], 0, 0, 0, 0, 0, 0, 0, 0);
    run(4, 0, 0, 0);

    // Stall: rdy low 7 cycles while word 1 is offered.
    idle(tab[3], 3, 4, 1);
    add(0, 0, 0, 0, 0, 1, 0, tab[3], 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, tab[0], 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, tab[0], 1, 0, 1);
    for (int k = 0; k < 7; k++)
      add(0, 0, 0, 0, 0, 0, 1, tab[1], 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, tab[1], 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0, tab[1], 1, 0, 2);
    add(0, 0, 0, 0, 0, 1, 1, tab[2], 1, 0, 2);
    add(0, 0, 0, 0, 0, 1, 0, tab[2], 1, 0, 3);
    add(0, 0, 0, 0, 0, 1, 1, tab[3], 1, 0, 3);
    add(0, 0, 0, 0, 0, 1, 0, tab[3], 1, 1, 3);
    idle(tab[3], 3, 0, 0);

    // Out-of-range starts are ignored.
    idle(tab[3], 3, 0, 1);
    idle(tab[3], 3, 0, 0);
    idle(tab[3], 3, 0, 0);
    idle(tab[3], 3, 17, 1);
    idle(tab[3], 3, 0, 0);
    idle(tab[3], 3, 0, 0);

    run(16, tab[3], 3, 0);
    run(4, tab[15], 15, 1);

    z = '{default: '0};
    rst = 1'b1;
    drive(z);
    repeat (2) @(negedge clk);
    outs("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    foreach (vq[i]) begin
      @(negedge clk);
      outs($sformatf("row%0d", i), vq[i].ev, vq[i].ed, vq[i].eb,
           vq[i].edn, vq[i].ec);
      drive(vq[i]);
    end

    // Mid-run reset while layer 1 is offered.
    @(negedge clk);
    z.num = 4; z.st = 1; z.rdy = 1;
    drive(z);
    @(negedge clk);
    z.st = 0;
    drive(z);
    @(negedge clk);
    outs("rs w0", 1, tab[0], 1, 0, 0);
    @(negedge clk);
    z.rdy = 0;
    drive(z);
    @(negedge clk);
    outs("rs w1", 1, tab[1], 1, 0, 1);
    rst = 1'b1;
    #1;
    outs("rs async", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    outs("rs hold", 0, 0, 0, 0, 0);
    z.num = 2; z.st = 1; z.rdy = 1;
    drive(z);
    @(negedge clk);
    z.st = 0;
    drive(z);
    outs("rr fetch", 0, 0, 1, 0, 0);
    @(negedge clk);
    outs("rr w0", 1, tab[0], 1, 0, 0);
    @(negedge clk);
    @(negedge clk);
    outs("rr w1", 1, tab[1], 1, 0, 1);
    @(negedge clk);
    outs("rr done", 0, tab[1], 1, 1, 1);
    @(negedge clk);
    outs("rr idle", 0, tab[1], 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ifcfg_tx.md
# ifcfg_tx

Transmit side of the IF→CCU layer-configuration link. Holds a host-loaded table of per-layer configuration words and delivers them in order to the CCU over the `IFCFG_val` / `CFGIF_rdy` / `IFCFG_data` handshake, one word per CCU request. Sits between the host/ASIC interface logic and the CCU, replacing the testbench-driven configuration source in the CCU bench.

## Interface

Parameters:
- `DATA_WIDTH`, default 128: width of one layer configuration word (`IFCFG_data`).
- `DEPTH`, default 16: number of layer-configuration entries; must be a power of two, ≥2.
- `AW`, default `$clog2(DEPTH)`: address width.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `host_wr_en`  in  1  write one table entry this cycle.
- `host_wr_addr`  in  AW  table write address.
- `host_wr_data`  in  DATA_WIDTH  table write data.
- `host_num_layer`  in  AW+1  number of layers to send, 1..DEPTH; sampled on `host_start`.
- `host_start`  in  1  single-cycle pulse that begins a run.
- `host_busy`  out  1  high from the cycle after an accepted start until the cycle `host_done` pulses.
- `host_done`  out  1  one-cycle pulse after the last word is accepted.
- `CFGIF_rdy`  in  1  CCU ready to take a configuration word.
- `IFCFG_val`  out  1  `IFCFG_data` is valid.
- `IFCFG_data`  out  DATA_WIDTH  configuration word.
- `cur_layer`  out  AW  index of the word currently offered or next to be offered.

## Operation

- Table: DEPTH×DATA_WIDTH register array, synchronous write, synchronous read (1-cycle).
- Host writes are honoured only when `host_busy`=0; writes while busy are dropped.
- FSM states: IDLE, FETCH, SEND, DONE.
  - IDLE: `host_start`=1 with `host_num_layer` in 1..DEPTH → latch count, `cur_layer`←0, go to FETCH. `host_num_layer`=0 or >DEPTH → start ignored, stay in IDLE.
  - FETCH: issue table read at `cur_layer`; next cycle → SEND.
  - SEND: `IFCFG_val`=1 and `IFCFG_data`=table[`cur_layer`]. Transfer occurs on a cycle with `IFCFG_val`&&`CFGIF_rdy`. On transfer: if `cur_layer`==count−1 → DONE, else `cur_layer`+1 → FETCH.
  - DONE: `host_done`=1 for one cycle → IDLE.
- Handshake rules: once `IFCFG_val` rises, it and `IFCFG_data` hold stable until the transfer; `CFGIF_rdy` dropping does not withdraw val. Val never depends combinationally on rdy.
- `host_start` while busy: ignored.
- Reset mid-run: FSM→IDLE immediately, val deasserted; table contents are not cleared by reset.

## Timing

- Reset values: `IFCFG_val`=0, `IFCFG_data`=0, `host_busy`=0, `host_done`=0, `cur_layer`=0, FSM=IDLE.
- `host_start` at cycle N → FETCH at N+1 → `IFCFG_val`=1 at N+2.
- Transfer at cycle T (not last) → val low at T+1 (FETCH) → val high at T+2 with next word. Max throughput one word per 2 cycles.
- Last transfer at T → `host_done`=1 at T+1, `host_busy`=0 at T+2 (IDLE); a new `host_start` is accepted from T+2.
- Table write at cycle W is visible to a FETCH at W+1 or later.
- All outputs are registered.

## Configuration

- `IFCFG_LOOP_EN` defined: after the last word transfers, `cur_layer` wraps to 0 and the FSM returns to FETCH instead of DONE; `host_done` pulses at each wrap (same cycle the FETCH of layer 0 begins) and `host_busy` stays high. The run ends only on `rst`.
- Not defined: single pass, behaviour as in Operation.

## Test plan

- Load entries 0..3 with 0xA0..0xA3, start with `host_num_layer`=4, `CFGIF_rdy` held 1 → val at start+2, words 0xA0,0xA1,0xA2,0xA3 each on a 2-cycle cadence, `host_done` one cycle after the 0xA3 transfer.
- Same load, `CFGIF_rdy` low for 7 cycles while val=1 on word 0xA1 → val and data held stable all 7 cycles, exactly one transfer of 0xA1, no duplicates/skips.
- `host_num_layer`=0 and =DEPTH+1 with `host_start` → `host_busy` stays 0, val never rises; `host_num_layer`=DEPTH=16 → 16 words sent in address order.
- Host write to address 2 (0xFF) and second `host_start` during a run → entry 2 still sends original value, run unaffected, no restart.
- Assert `rst` for one cycle while val=1 on layer 1 → val=0, busy=0, `cur_layer`=0 immediately; restart sends from layer 0 with table intact.
- With `IFCFG_LOOP_EN`, `host_num_layer`=2 → sequence A0,A1,A0,A1,…, `host_done` pulse each wrap, `host_busy` never drops.
